// File: rtl/bootrom_pkg.sv
// Shared definitions for the boot ROM loader.
//   boot_state_t       : copy-engine state encoding (IDLE, COPY, DONE)
//   BOOT_IMAGE_DEFAULT : default 8 x 16 boot image, word i at [i*16 +: 16]
//   rom_word()         : extracts one word from a packed image
package bootrom_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        COPY = 2'd1,
        DONE = 2'd2
    } boot_state_t;

    // Word 0 sits in the least significant 16 bits (0xF200).
    localparam logic [127:0] BOOT_IMAGE_DEFAULT = {
        16'h0008, 16'h4000, 16'h4000, 16'hB008,
        16'hF400, 16'hF800, 16'h4000, 16'hF200
    };

    // Upper bounds on packed image size and word width that rom_word accepts.
    localparam int unsigned IMG_MAX_BITS  = 4096;
    localparam int unsigned WORD_MAX_BITS = 64;

    // Returns word idx of a packed image whose words are width bits wide.
    // With a constant image this folds into a constant mux.
    function automatic logic [WORD_MAX_BITS-1:0] rom_word(
        input logic [IMG_MAX_BITS-1:0] image,
        input int unsigned             idx,
        input int unsigned             width
    );
        logic [WORD_MAX_BITS-1:0] mask;
        if (width >= WORD_MAX_BITS) begin
            mask = '1;
        end else begin
            mask = (64'd1 << width) - 64'd1;
        end
        return WORD_MAX_BITS'(image >> (idx * width)) & mask;
    endfunction

endpackage

// File: rtl/bootrom_image.sv
// Purely combinational constant lookup into the boot image.
//   idx_i  : word index (AW bits)
//   word_o : image word at idx_i, or zero when idx_i >= DEPTH
module bootrom_image
    import bootrom_pkg::*;
#(
    parameter int                     WIDTH = 16,
    parameter int                     DEPTH = 8,
    parameter int                     AW    = $clog2(DEPTH),
    parameter logic [DEPTH*WIDTH-1:0] INIT  = '0
) (
    input  logic [AW-1:0]    idx_i,
    output logic [WIDTH-1:0] word_o
);

    // Constant image mux; indices past the image read as zero.
    always_comb begin
        if (int'(idx_i) < DEPTH) begin
            word_o = WIDTH'(rom_word(IMG_MAX_BITS'(INIT), 32'(idx_i), 32'(WIDTH)));
        end else begin
            word_o = '0;
        end
    end

endmodule

// File: rtl/bootrom_loader.sv
// Boot ROM loader: copies a constant DEPTH x WIDTH image into main memory
// after reset, then raises boot_done. Also offers a registered CPU read port.
//   clk, rst (async, active-low)  start : re-run copy (DONE only)
//   cs, we, addr -> dout, dout_valid, wr_err (sticky write-attempt flag)
//   mem_req/mem_gnt/mem_addr/mem_din : copy-engine write port
//   busy : copy in progress   boot_done : image fully copied
module bootrom_loader
    import bootrom_pkg::*;
#(
    parameter int                     WIDTH  = 16,
    parameter int                     DEPTH  = 8,
    parameter int                     AW     = $clog2(DEPTH),
    parameter int                     MEM_AW = 12,
    parameter logic [MEM_AW-1:0]      BASE   = '0,
    parameter logic [DEPTH*WIDTH-1:0] INIT   = BOOT_IMAGE_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              cs,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    output logic [WIDTH-1:0]  dout,
    output logic              dout_valid,
    output logic              wr_err,
    output logic              mem_req,
    input  logic              mem_gnt,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [WIDTH-1:0]  mem_din,
    output logic              busy,
    output logic              boot_done
);

    boot_state_t       state_q, state_d;
    logic [AW-1:0]     idx_q, idx_d;
    logic              mem_req_q, mem_req_d;
    logic [MEM_AW-1:0] mem_addr_q, mem_addr_d;
    logic [WIDTH-1:0]  mem_din_q, mem_din_d;
    logic              busy_q, busy_d;
    logic              boot_done_q, boot_done_d;
    logic [WIDTH-1:0]  dout_q, dout_d;
    logic              dout_valid_q, dout_valid_d;
    logic              wr_err_q, wr_err_d;

    logic              last_s;
    logic [WIDTH-1:0]  copy_word_s;
    logic [WIDTH-1:0]  rd_word_s;

    assign last_s = (idx_q == AW'(DEPTH - 1));

    // Next copy index; the write port is loaded with the word at this index,
    // so the ROM lookup is driven from it rather than from idx_q.
    always_comb begin
        idx_d = idx_q;
        case (state_q)
            IDLE: begin
                idx_d = '0;
            end
            COPY: begin
                if (mem_gnt && !last_s) begin
                    idx_d = idx_q + AW'(1);
                end else begin
                    idx_d = idx_q;
                end
            end
            DONE: begin
                if (start) begin
                    idx_d = '0;
                end else begin
                    idx_d = idx_q;
                end
            end
            default: begin
                idx_d = '0;
            end
        endcase
    end

    bootrom_image #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW), .INIT(INIT)
    ) u_copy_rom (
        .idx_i  (idx_d),
        .word_o (copy_word_s)
    );

    bootrom_image #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW), .INIT(INIT)
    ) u_read_rom (
        .idx_i  (addr),
        .word_o (rd_word_s)
    );

    // Copy-engine FSM: request/address/data hold until granted.
    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_addr_d  = mem_addr_q;
        mem_din_d   = mem_din_q;
        busy_d      = busy_q;
        boot_done_d = boot_done_q;
        case (state_q)
            IDLE: begin
                state_d     = COPY;
                mem_req_d   = 1'b1;
                busy_d      = 1'b1;
                boot_done_d = 1'b0;
                mem_addr_d  = BASE + MEM_AW'(idx_d);
                mem_din_d   = copy_word_s;
            end
            COPY: begin
                if (mem_gnt && last_s) begin
                    state_d     = DONE;
                    mem_req_d   = 1'b0;
                    busy_d      = 1'b0;
                    boot_done_d = 1'b1;
                end else if (mem_gnt) begin
                    mem_addr_d  = BASE + MEM_AW'(idx_d);
                    mem_din_d   = copy_word_s;
                end else begin
                    state_d     = COPY;
                end
            end
            DONE: begin
                if (start) begin
                    state_d     = COPY;
                    mem_req_d   = 1'b1;
                    busy_d      = 1'b1;
                    boot_done_d = 1'b0;
                    mem_addr_d  = BASE + MEM_AW'(idx_d);
                    mem_din_d   = copy_word_s;
                end else begin
                    state_d     = DONE;
                end
            end
            default: begin
                state_d     = IDLE;
                mem_req_d   = 1'b0;
                busy_d      = 1'b0;
                boot_done_d = 1'b0;
            end
        endcase
    end

    // CPU read port, independent of the copy engine.
    always_comb begin
        dout_d       = dout_q;
        dout_valid_d = 1'b0;
        wr_err_d     = wr_err_q;
        if (cs && !we) begin
            dout_d       = rd_word_s;
            dout_valid_d = 1'b1;
        end else if (cs && we) begin
            wr_err_d     = 1'b1;
        end else begin
            dout_valid_d = 1'b0;
        end
    end

    // State and output registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            mem_req_q    <= 1'b0;
            mem_addr_q   <= '0;
            mem_din_q    <= '0;
            busy_q       <= 1'b0;
            boot_done_q  <= 1'b0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            wr_err_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            mem_req_q    <= mem_req_d;
            mem_addr_q   <= mem_addr_d;
            mem_din_q    <= mem_din_d;
            busy_q       <= busy_d;
            boot_done_q  <= boot_done_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            wr_err_q     <= wr_err_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign wr_err     = wr_err_q;
    assign mem_req    = mem_req_q;
    assign mem_addr   = mem_addr_q;
    assign mem_din    = mem_din_q;
    assign busy       = busy_q;
    assign boot_done  = boot_done_q;

endmodule
